// File: rtl/conv_operand_loader.sv
// Operand loader for the convolution engines: assembles a serial byte stream
// into the A matrix and B kernel, raises run once a full frame is held, and
// re-arms for the next frame when the engines signal completion.
module conv_operand_loader #(
    parameter int DATA_W = 8,
    parameter int A_N    = 4,
    parameter int B_N    = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    input  logic                          engine_done,
    output logic [A_N*A_N*DATA_W-1:0]     a_flat,
    output logic [B_N*B_N*DATA_W-1:0]     b_flat,
    output logic                          run,
    output logic                          sof_err,
    output logic [7:0]                    frame_cnt,
    output logic                          state
);

    localparam int NA    = A_N * A_N;
    localparam int NB    = B_N * B_N;
    localparam int NW    = NA + NB;
    localparam int IDX_W = $clog2(NW);

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                run_q, run_d;
    logic                sof_err_q, sof_err_d;
    logic [7:0]          cnt_q, cnt_d;

    // Element storage: element k (stream order) lives at bits [k*DATA_W +: DATA_W],
    // so A occupies the low NA elements and B the NB elements above it.
    logic [NW*DATA_W-1:0] elem_q;
    logic                 wr_en;
    logic [IDX_W-1:0]     wr_addr;
    logic                 accept;

    assign in_ready = (state_q == LOAD) && !reset;
    assign accept   = in_valid && in_ready;

    // Next-state logic: framing checks, element addressing and run handshake.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        run_d     = run_q;
        sof_err_d = 1'b0;
        cnt_d     = cnt_q;
        wr_en     = 1'b0;
        wr_addr   = idx_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    if ((idx_q == '0) && !in_sof) begin
                        // Stray byte before any start of frame: drop it.
                        sof_err_d = 1'b1;
                    end else if ((idx_q != '0) && in_sof) begin
                        // New frame started early: restart at element 0.
                        sof_err_d = 1'b1;
                        wr_en     = 1'b1;
                        wr_addr   = '0;
                        idx_d     = IDX_W'(1);
                    end else begin
                        wr_en = 1'b1;
                        if (idx_q == IDX_W'(NW - 1)) begin
                            idx_d   = '0;
                            state_d = RUN;
                            run_d   = 1'b1;
                            cnt_d   = cnt_q + 8'd1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
            end
            RUN: begin
                if (engine_done) begin
                    state_d = LOAD;
                    run_d   = 1'b0;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LOAD;
            idx_q     <= '0;
            run_q     <= 1'b0;
            sof_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            run_q     <= run_d;
            sof_err_q <= sof_err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Element registers: only the addressed element is written, reset clears all.
    always_ff @(posedge clk) begin
        if (reset) begin
            elem_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NW; i++) begin
                if (wr_addr == IDX_W'(i)) begin
                    elem_q[i*DATA_W +: DATA_W] <= in_data;
                end
            end
        end
    end

    assign a_flat    = elem_q[NA*DATA_W-1:0];
    assign b_flat    = elem_q[NW*DATA_W-1:NA*DATA_W];
    assign run       = run_q;
    assign sof_err   = sof_err_q;
    assign frame_cnt = cnt_q;
    assign state     = state_q;

endmodule

// File: tb/tb_conv_operand_loader.sv
// Self-checking bench for conv_operand_loader: directed scenarios with random
// data, compared every cycle against a frame-buffer reference model.
module tb_conv_operand_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_sof;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         engine_done;
    logic [127:0] a_flat;
    logic [71:0]  b_flat;
    logic         run;
    logic         sof_err;
    logic [7:0]   frame_cnt;
    logic         state;

    int checks = 0;
    int errors = 0;

    // Reference model: the 25-byte frame buffer, write position, run flag,
    // error pulse and completed frame count.
    logic [7:0] m_mem [25];
    int         m_pos;
    bit         m_run;
    bit         m_err;
    int         m_cnt;

    conv_operand_loader #(.DATA_W(8), .A_N(4), .B_N(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
        .in_data(in_data), .in_ready(in_ready), .engine_done(engine_done),
        .a_flat(a_flat), .b_flat(b_flat), .run(run), .sof_err(sof_err),
        .frame_cnt(frame_cnt), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 25; i++) m_mem[i] = 8'd0;
        m_pos = 0; m_run = 0; m_err = 0; m_cnt = 0;
    endfunction

    function automatic void m_edge(bit rst, bit v, bit sof, logic [7:0] d, bit done);
        m_err = 0;
        if (rst) begin
            m_reset();
        end else if (!m_run) begin
            if (v) begin
                if (m_pos == 0 && !sof) begin
                    m_err = 1;
                end else if (m_pos != 0 && sof) begin
                    m_err = 1;
                    m_mem[0] = d;
                    m_pos = 1;
                end else begin
                    m_mem[m_pos] = d;
                    m_pos++;
                    if (m_pos == 25) begin
                        m_pos = 0;
                        m_run = 1;
                        m_cnt = (m_cnt + 1) % 256;
                    end
                end
            end
        end else if (done) begin
            m_run = 0;
            m_pos = 0;
        end
    endfunction

    function automatic logic [127:0] exp_a();
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = m_mem[i];
        return r;
    endfunction

    function automatic logic [71:0] exp_b();
        logic [71:0] r = '0;
        for (int i = 0; i < 9; i++) r[i*8 +: 8] = m_mem[16 + i];
        return r;
    endfunction

    task automatic check_all();
        chk("in_ready", in_ready, !m_run && !reset);
        chk("run", run, m_run);
        chk("state", state, m_run);
        chk("sof_err", sof_err, m_err);
        chk("frame_cnt", frame_cnt, 8'(m_cnt));
        chk("a_flat", a_flat, exp_a());
        chk("b_flat", b_flat, exp_b());
    endtask

    // One clock edge: model consumes the inputs held across the edge, then compare.
    task automatic tick();
        @(posedge clk);
        m_edge(reset, in_valid, in_sof, in_data, engine_done);
        #1;
        check_all();
    endtask

    task automatic send_byte(input bit sof, input logic [7:0] d);
        in_valid = 1'b1; in_sof = sof; in_data = d;
        tick();
        in_valid = 1'b0; in_sof = 1'b0; in_data = 8'($urandom_range(0, 255));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0; in_data = 8'($urandom_range(0, 255));
            tick();
        end
    endtask

    task automatic release_engines();
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
    endtask

    // Random frame; when throttled, every byte is followed by an idle cycle in
    // which engine_done is toggled randomly (LOAD ignores it).
    task automatic send_frame(input bit throttle);
        for (int i = 0; i < 25; i++) begin
            send_byte(i == 0, 8'($urandom_range(0, 255)));
            if (throttle && i != 24) begin
                engine_done = 1'($urandom_range(0, 1));
                idle(1);
                engine_done = 1'b0;
            end
        end
    endtask

    logic [7:0]   fa [16];
    logic [7:0]   fb [9];
    logic [127:0] a_saved;
    logic [71:0]  b_saved;
    logic [7:0]   rs_byte;

    initial begin
        fa = '{3,1,6,5, 7,5,2,7, 7,10,8,9, 1,3,2,10};
        fb = '{3,1,4, 0,5,1, 0,1,5};
        m_reset();
        reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'd0; engine_done = 1'b0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("in_ready_after_reset", in_ready, 1'b1);

        // Full known frame
        for (int i = 0; i < 16; i++) send_byte(i == 0, fa[i]);
        for (int i = 0; i < 9; i++) send_byte(1'b0, fb[i]);
        chk("f1_run", run, 1'b1);
        chk("f1_cnt", frame_cnt, 8'd1);
        chk("f1_a11", a_flat[7:0], 8'd3);
        chk("f1_a44", a_flat[127:120], 8'd10);
        chk("f1_a23", a_flat[55:48], 8'd2);
        chk("f1_b11", b_flat[7:0], 8'd3);
        chk("f1_b33", b_flat[71:64], 8'd5);

        // Hold during RUN with valid traffic, then release
        a_saved = a_flat; b_saved = b_flat;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_sof = 1'($urandom_range(0, 1));
            in_data = 8'($urandom_range(0, 255));
            tick();
            chk("hold_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0; in_sof = 1'b0;
        chk("hold_a", a_flat, a_saved);
        chk("hold_b", b_flat, b_saved);
        release_engines();
        chk("rel_run", run, 1'b0);
        chk("rel_state", state, 1'b0);
        chk("rel_ready", in_ready, 1'b1);
        chk("rel_a_kept", a_flat, a_saved);

        // Resync on the 11th byte
        for (int i = 0; i < 10; i++) send_byte(i == 0, 8'($urandom_range(0, 255)));
        rs_byte = 8'($urandom_range(0, 255));
        send_byte(1'b1, rs_byte);
        chk("rs_err_pulse", sof_err, 1'b1);
        idle(1);
        chk("rs_err_clear", sof_err, 1'b0);
        for (int i = 0; i < 24; i++) send_byte(1'b0, 8'($urandom_range(0, 255)));
        chk("rs_run", run, 1'b1);
        chk("rs_elem0", a_flat[7:0], rs_byte);
        release_engines();

        // Missing SOF from idle
        a_saved = a_flat;
        for (int i = 0; i < 3; i++) begin
            send_byte(1'b0, 8'($urandom_range(0, 255)));
            chk("nosof_err", sof_err, 1'b1);
        end
        chk("nosof_a", a_flat, a_saved);
        send_frame(1'b0);
        chk("nosof_run", run, 1'b1);
        release_engines();

        // Reset mid-load
        for (int i = 0; i < 12; i++) send_byte(i == 0, 8'($urandom_range(0, 255)));
        reset = 1'b1;
        tick();
        chk("rst_a", a_flat, 128'd0);
        chk("rst_run", run, 1'b0);
        chk("rst_ready", in_ready, 1'b0);
        reset = 1'b0;
        send_frame(1'b0);
        chk("rst_cnt", frame_cnt, 8'd1);
        release_engines();

        // Throttled stream, two frames
        send_frame(1'b1);
        chk("thr_run1", run, 1'b1);
        idle(2);
        release_engines();
        send_frame(1'b1);
        chk("thr_run2", run, 1'b1);
        chk("thr_cnt", frame_cnt, 8'd3);
        release_engines();
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
